opcode_fetch_assembler: RTL and testbench

Parametrised instruction assembler between the byte-wide instruction memory and the decoder. It accepts a byte stream, looks up the opcode in a runtime-writable class table, collects 0..MAX_OPERANDS operand bytes, and presents one complete instruction with its class flags on a valid/ready output. The class table replaces the fixed per-opcode lookup with per-opcode operand counts, N_CLASSES flag bits, and reprogrammable contents.

---
 rtl/fetch_decode_pkg.sv | 53 +++++
 rtl/opcode_class_table.sv | 69 ++++++
 rtl/opcode_fetch_assembler.sv | 178 +++++++++++++++++
 tb/tb_opcode_fetch_assembler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the opcode fetch/assembly path.
// Contents:
//   fetch_state_e        - assembler FSM states (IDLE / OPERAND / HOLD)
//   CLS_* indices        - bit positions of the per-opcode class flags
//   READ_CODES/MOV_CODES - opcodes that carry default table contents
//   is_read_code/is_mov_code - membership tests against those lists
//   clamp_nops           - saturate a requested operand count to the maximum
package fetch_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_HOLD    = 2'd2
  } fetch_state_e;

  localparam int CLS_READ_OPERAND     = 0;
  localparam int CLS_MOV_WITH_ADDRESS = 1;

  localparam int N_READ_CODES = 22;
  localparam int N_MOV_CODES  = 9;

  // Opcodes that take one operand byte and set READ_OPERAND by default.
  localparam logic [7:0] READ_CODES [N_READ_CODES] = '{
    8'h11, 8'h13, 8'h19, 8'h1B, 8'h21, 8'h23, 8'h31, 8'h39, 8'h3B, 8'h41, 8'h49,
    8'h4B, 8'h61, 8'h69, 8'h71, 8'h79, 8'h81, 8'h89, 8'hA1, 8'hA5, 8'hA9, 8'hC1
  };

  // Subset of the above that additionally sets MOV_WITH_ADDRESS.
  localparam logic [7:0] MOV_CODES [N_MOV_CODES] = '{
    8'h11, 8'h13, 8'h21, 8'h23, 8'h31, 8'h41, 8'h61, 8'h71, 8'h81
  };

  // Comparison is by numeric value, so narrower opcode widths simply never
  // match codes they cannot represent.
  function automatic logic is_read_code(input int unsigned idx);
    for (int i = 0; i < N_READ_CODES; i++) begin
      if (32'(READ_CODES[i]) == idx) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic is_mov_code(input int unsigned idx);
    for (int i = 0; i < N_MOV_CODES; i++) begin
      if (32'(MOV_CODES[i]) == idx) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int unsigned clamp_nops(input int unsigned n, input int unsigned max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/opcode_class_table.sv
// Runtime-writable per-opcode class table: one {nops, flags} entry per opcode.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (restores defaults)
//   we/waddr      - write strobe and opcode entry to write
//   wnops/wflags  - operand count (saturated to MAX_OPERANDS) and class flags
//   raddr         - opcode to look up (combinational read)
//   rnops/rflags  - looked-up entry; reflects writes from the next cycle on
module opcode_class_table
  import fetch_decode_pkg::*;
#(
  parameter int OPCODE_W     = 8,
  parameter int N_CLASSES    = 2,
  parameter int MAX_OPERANDS = 2,
  parameter int NOPS_W       = $clog2(MAX_OPERANDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [OPCODE_W-1:0]  waddr,
  input  logic [NOPS_W-1:0]    wnops,
  input  logic [N_CLASSES-1:0] wflags,
  input  logic [OPCODE_W-1:0]  raddr,
  output logic [NOPS_W-1:0]    rnops,
  output logic [N_CLASSES-1:0] rflags
);

  localparam int N_ENTRIES = 2 ** OPCODE_W;

  logic [NOPS_W-1:0]    nops_q  [N_ENTRIES];
  logic [NOPS_W-1:0]    nops_d  [N_ENTRIES];
  logic [N_CLASSES-1:0] flags_q [N_ENTRIES];
  logic [N_CLASSES-1:0] flags_d [N_ENTRIES];

  function automatic logic [N_CLASSES-1:0] default_flags(input int unsigned idx);
    logic [N_CLASSES-1:0] f;
    f = '0;
    for (int b = 0; b < N_CLASSES; b++) begin
      if (b == CLS_READ_OPERAND)          f[b] = is_read_code(idx);
      else if (b == CLS_MOV_WITH_ADDRESS) f[b] = is_mov_code(idx);
    end
    return f;
  endfunction

  always_comb begin
    nops_d  = nops_q;
    flags_d = flags_q;
    if (we) begin
      nops_d[waddr]  = NOPS_W'(clamp_nops(32'(wnops), 32'(MAX_OPERANDS)));
      flags_d[waddr] = wflags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        nops_q[i]  <= is_read_code(i) ? NOPS_W'(1) : '0;
        flags_q[i] <= default_flags(i);
      end
    end else begin
      nops_q  <= nops_d;
      flags_q <= flags_d;
    end
  end

  // A write in the same cycle as a lookup is seen only from the next cycle.
  assign rnops  = nops_q[raddr];
  assign rflags = flags_q[raddr];

endmodule

// File: rtl/opcode_fetch_assembler.sv
// Assembles a byte stream into whole instructions for the decoder.
// Each opcode byte is looked up in opcode_class_table to learn how many
// operand bytes follow and which class flags apply; the finished instruction
// is presented on a valid/ready output.
//
// Handshakes: a byte transfers on the input when in_valid & in_ready in the
// same cycle; an instruction transfers on the output when out_valid &
// out_ready. out_valid and the out_* fields stay stable until the transfer.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid/in_ready/in_data - byte stream from instruction memory
//   flush                     - drop any partial or held instruction
//   out_valid/out_ready       - instruction handshake to the decoder
//   out_opcode/out_operands/out_nops/out_flags - assembled instruction
//   cfg_we/cfg_addr/cfg_nops/cfg_flags - class table write port
//   busy                      - high whenever the FSM is not IDLE
module opcode_fetch_assembler
  import fetch_decode_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int OPCODE_W     = 8,
  parameter int N_CLASSES    = 2,
  parameter int MAX_OPERANDS = 2,
  parameter int NOPS_W       = $clog2(MAX_OPERANDS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OPCODE_W-1:0]            out_opcode,
  output logic [MAX_OPERANDS*DATA_W-1:0] out_operands,
  output logic [NOPS_W-1:0]              out_nops,
  output logic [N_CLASSES-1:0]           out_flags,
  input  logic                           cfg_we,
  input  logic [OPCODE_W-1:0]            cfg_addr,
  input  logic [NOPS_W-1:0]              cfg_nops,
  input  logic [N_CLASSES-1:0]           cfg_flags,
  output logic                           busy
);

  fetch_state_e state_q, state_d;

  logic [OPCODE_W-1:0]            opcode_q, opcode_d;
  logic [MAX_OPERANDS*DATA_W-1:0] slots_q, slots_d;
  logic [NOPS_W-1:0]              nops_q, nops_d;
  logic [N_CLASSES-1:0]           flags_q, flags_d;
  logic [NOPS_W-1:0]              count_q, count_d;

  logic [NOPS_W-1:0]    tbl_nops;
  logic [N_CLASSES-1:0] tbl_flags;
  logic                 accept;
  logic                 load_opcode;
  logic                 collect;

  // The incoming byte is always presented to the table; it is only used when
  // that byte is accepted as an opcode.
  opcode_class_table #(
    .OPCODE_W     (OPCODE_W),
    .N_CLASSES    (N_CLASSES),
    .MAX_OPERANDS (MAX_OPERANDS),
    .NOPS_W       (NOPS_W)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wnops  (cfg_nops),
    .wflags (cfg_flags),
    .raddr  (in_data[OPCODE_W-1:0]),
    .rnops  (tbl_nops),
    .rflags (tbl_flags)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: outputs ----------------
  // in_ready is the only output with a combinational input path; in HOLD a
  // new opcode can enter in the very cycle the held instruction leaves.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = (state_q == ST_HOLD);
    busy      = (state_q != ST_IDLE);
    if (!rst && !flush) begin
      case (state_q)
        ST_IDLE, ST_OPERAND: in_ready = 1'b1;
        ST_HOLD:             in_ready = out_ready;
        default:             in_ready = 1'b0;
      endcase
    end
  end

  assign accept      = in_valid & in_ready;
  assign load_opcode = accept & ((state_q == ST_IDLE) | (state_q == ST_HOLD));
  assign collect     = accept & (state_q == ST_OPERAND);

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_d = (tbl_nops == '0) ? ST_HOLD : ST_OPERAND;
        end
        ST_OPERAND: begin
          if (accept && (count_q + NOPS_W'(1) == nops_q)) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (accept) state_d = (tbl_nops == '0) ? ST_HOLD : ST_OPERAND;
            else        state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- datapath ----------------
  always_comb begin
    opcode_d = opcode_q;
    slots_d  = slots_q;
    nops_d   = nops_q;
    flags_d  = flags_q;
    count_d  = count_q;
    if (flush) begin
      opcode_d = '0;
      slots_d  = '0;
      nops_d   = '0;
      flags_d  = '0;
      count_d  = '0;
    end else if (load_opcode) begin
      // Slots are cleared here so unused operand positions read zero.
      opcode_d = in_data[OPCODE_W-1:0];
      slots_d  = '0;
      nops_d   = tbl_nops;
      flags_d  = tbl_flags;
      count_d  = '0;
    end else if (collect) begin
      for (int i = 0; i < MAX_OPERANDS; i++) begin
        if (count_q == NOPS_W'(i)) slots_d[i*DATA_W +: DATA_W] = in_data;
      end
      count_d = count_q + NOPS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      slots_q  <= '0;
      nops_q   <= '0;
      flags_q  <= '0;
      count_q  <= '0;
    end else begin
      opcode_q <= opcode_d;
      slots_q  <= slots_d;
      nops_q   <= nops_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
    end
  end

  assign out_opcode   = opcode_q;
  assign out_operands = slots_q;
  assign out_nops     = nops_q;
  assign out_flags    = flags_q;

endmodule

// File: tb/tb_opcode_fetch_assembler.sv
module tb_opcode_fetch_assembler;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [15:0] out_operands;
  logic [1:0]  out_nops;
  logic [1:0]  out_flags;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [1:0]  cfg_nops;
  logic [1:0]  cfg_flags;
  logic        busy;

  opcode_fetch_assembler dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_operands (out_operands),
    .out_nops     (out_nops),
    .out_flags    (out_flags),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_nops     (cfg_nops),
    .cfg_flags    (cfg_flags),
    .busy         (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int read_codes [22] = '{'h11, 'h13, 'h19, 'h1B, 'h21, 'h23, 'h31, 'h39, 'h3B, 'h41, 'h49,
                          'h4B, 'h61, 'h69, 'h71, 'h79, 'h81, 'h89, 'hA1, 'hA5, 'hA9, 'hC1};
  int mov_codes  [9]  = '{'h11, 'h13, 'h21, 'h23, 'h31, 'h41, 'h61, 'h71, 'h81};

  int         m_nops  [256];
  logic [1:0] m_flags [256];

  // Expected instruction packed as {flags[27:26], nops[25:24], operands[23:8], opcode[7:0]}
  logic [27:0] exp_q[$];
  bit          collecting;
  logic [7:0]  c_op;
  logic [15:0] c_ops;
  int          c_need;
  int          c_have;
  logic [1:0]  c_flags;
  bit          armed = 1'b0;

  task automatic model_table_defaults();
    for (int i = 0; i < 256; i++) begin
      m_nops[i]  = 0;
      m_flags[i] = 2'b00;
    end
    foreach (read_codes[i]) begin
      m_nops[read_codes[i]]     = 1;
      m_flags[read_codes[i]][0] = 1'b1;
    end
    foreach (mov_codes[i]) m_flags[mov_codes[i]][1] = 1'b1;
  endtask

  task automatic model_cfg_write();
    if (cfg_we) begin
      m_nops[cfg_addr]  = (cfg_nops > 2) ? 2 : int'(cfg_nops);
      m_flags[cfg_addr] = cfg_flags;
    end
  endtask

  task automatic push_current();
    exp_q.push_back({c_flags, 2'(c_need), c_ops, c_op});
  endtask

  // Compare process: checks DUT state at each negedge against the model,
  // then advances the model by what the coming edge will do.
  always @(negedge clk) begin
    bit          rdy;
    logic [27:0] e;
    rdy = !rst && !flush && (exp_q.size() == 0 || out_ready);
    if (armed || rst) check("in_ready", in_ready, rdy);
    if (armed) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("busy", busy, collecting || exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("out_opcode", out_opcode, e[7:0]);
        check("out_operands", out_operands, e[23:8]);
        check("out_nops", out_nops, e[25:24]);
        check("out_flags", out_flags, e[27:26]);
      end
    end

    if (rst) begin
      model_table_defaults();
      exp_q.delete();
      collecting = 1'b0;
      armed      = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      collecting = 1'b0;
      model_cfg_write();
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && rdy) begin
        if (collecting) begin
          c_ops  = c_ops | (16'(in_data) << (8 * c_have));
          c_have = c_have + 1;
          if (c_have == c_need) begin
            push_current();
            collecting = 1'b0;
          end
        end else begin
          c_op    = in_data;
          c_ops   = 16'h0;
          c_have  = 0;
          c_need  = m_nops[in_data];
          c_flags = m_flags[in_data];
          if (c_need == 0) push_current();
          else collecting = 1'b1;
        end
      end
      model_cfg_write();
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic we, input logic [7:0] a, input logic [1:0] n, input logic [1:0] f);
    cfg_we    = we;
    cfg_addr  = a;
    cfg_nops  = n;
    cfg_flags = f;
  endtask

  logic [7:0] op_pool [10] = '{8'h11, 8'h13, 8'h19, 8'h21, 8'h50, 8'h00, 8'hA5, 8'hC1, 8'h3B, 8'h7F};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b0;
    set_cfg(1'b0, 8'h00, 2'd0, 2'b00);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_opcode", out_opcode, 8'h00);
    check("rst_operands", out_operands, 16'h0000);
    check("rst_nops", out_nops, 2'd0);
    check("rst_flags", out_flags, 2'b00);
    check("rst_busy", busy, 1'b0);

    // 0x11,0xAB then 0x00 back to back
    out_ready = 1'b1;
    step(); in_valid = 1'b1; in_data = 8'h11;
    step(); in_data = 8'hAB;
    step(); in_data = 8'h00;
    @(negedge clk);
    check("t1_opcode", out_opcode, 8'h11);
    check("t1_operands", out_operands, 16'h00AB);
    check("t1_nops", out_nops, 2'd1);
    check("t1_flags", out_flags, 2'b11);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("t1b_valid", out_valid, 1'b1);
    check("t1b_opcode", out_opcode, 8'h00);
    check("t1b_operands", out_operands, 16'h0000);
    check("t1b_nops_flags", {out_nops, out_flags}, 4'h0);

    // reprogram 0x50 to two operands
    step(); set_cfg(1'b1, 8'h50, 2'd2, 2'b01);
    step(); set_cfg(1'b0, 8'h00, 2'd0, 2'b00); in_valid = 1'b1; in_data = 8'h50;
    step(); in_data = 8'h12;
    step(); in_data = 8'h34;
    @(negedge clk);
    check("t2_not_early", out_valid, 1'b0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("t2_valid", out_valid, 1'b1);
    check("t2_operands", out_operands, 16'h3412);
    check("t2_nops", out_nops, 2'd2);
    check("t2_flags", out_flags, 2'b01);

    // back-pressure for 5 cycles, then release with a byte waiting
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h19;
    @(negedge clk);
    check("t3_stall_ready", in_ready, 1'b0);
    check("t3_stall_opcode", out_opcode, 8'h50);
    repeat (4) begin
      step();
      @(negedge clk);
      check("t3_stall_ready", in_ready, 1'b0);
      check("t3_stall_ops", out_operands, 16'h3412);
    end
    step(); out_ready = 1'b1;
    step(); in_data = 8'h77;
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("t3_opcode", out_opcode, 8'h19);
    check("t3_operands", out_operands, 16'h0077);
    check("t3_flags", out_flags, 2'b01);

    // flush mid-instruction
    step();
    step(); in_valid = 1'b1; in_data = 8'h50;
    step(); in_data = 8'h12;
    step(); in_valid = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    check("t4_flush_valid", out_valid, 1'b0);
    check("t4_flush_busy", busy, 1'b0);
    in_valid = 1'b1; in_data = 8'h19;
    step(); in_data = 8'h77;
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("t4_opcode", out_opcode, 8'h19);
    check("t4_operands", out_operands, 16'h0077);
    check("t4_flags", out_flags, 2'b01);

    // table write to 0x19 in the same cycle 0x19 is accepted
    step(); in_valid = 1'b1; in_data = 8'h19; set_cfg(1'b1, 8'h19, 2'd2, 2'b10);
    step(); set_cfg(1'b0, 8'h00, 2'd0, 2'b00); in_data = 8'h55;
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("t5_old_nops", out_nops, 2'd1);
    check("t5_old_flags", out_flags, 2'b01);
    in_valid = 1'b1; in_data = 8'h19;
    step(); in_data = 8'hAA;
    step(); in_data = 8'hBB;
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("t5_new_nops", out_nops, 2'd2);
    check("t5_new_flags", out_flags, 2'b10);
    check("t5_new_ops", out_operands, 16'hBBAA);

    // reset mid-OPERAND restores the table
    step(); in_valid = 1'b1; in_data = 8'h50;
    step(); in_data = 8'h01;
    step(); in_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("t6_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_outs", {out_opcode, out_operands, out_nops, out_flags}, 32'h0);
    in_valid = 1'b1; in_data = 8'h50;
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("t6_default_valid", out_valid, 1'b1);
    check("t6_default_nops", out_nops, 2'd0);
    check("t6_default_opcode", out_opcode, 8'h50);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      in_valid  = ($urandom_range(0, 99) < 75);
      in_data   = ($urandom_range(0, 1) == 1) ? op_pool[$urandom_range(0, 9)] : 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 3);
      set_cfg(($urandom_range(0, 99) < 8), op_pool[$urandom_range(0, 9)],
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    step();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_cfg(1'b0, 8'h00, 2'd0, 2'b00);
    repeat (4) step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
